// File: rtl/imem_resp_pkg.sv
// Shared types and configuration for the on-chip memory responder.
package imem_resp_pkg;

  localparam int unsigned imem_ram_depth   = 14;
  localparam int unsigned imem_wait_cycles = 0;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_wait = 2'd1,
    st_resp = 2'd2
  } imem_state_e;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/imem_ram.sv
// Word RAM with byte-lane writes and a registered, write-first read port.
module imem_ram import imem_resp_pkg::*; #(
  parameter int unsigned ram_depth = imem_ram_depth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ram_depth-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 re,
  input  logic [ram_depth-1:0] raddr,
  output logic [31:0]          rdata
);

  localparam int unsigned words = 1 << ram_depth;

  logic [31:0] mem [words];
  logic [31:0] rd_word;

  // A read colliding with a same-edge write sees the freshly written lanes.
  always_comb begin
    rd_word = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Output register stays zero except on the cycle following a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= re ? rd_word : '0;
  end

endmodule

// File: rtl/imem_resp.sv
// Slave end of the core memory port: one outstanding request, fixed wait-state latency.
module imem_resp import imem_resp_pkg::*; #(
  parameter int unsigned ram_depth   = imem_ram_depth,
  parameter logic [31:0] base_addr   = 32'h0,
  parameter int unsigned wait_cycles = imem_wait_cycles
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out
);

  localparam int unsigned tag_lsb = ram_depth + 2;

  typedef struct packed {
    imem_state_e          state;
    logic [3:0]           cnt;
    logic [ram_depth-1:0] idx;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 write;
    logic                 in_range;
  } regs_t;

  localparam regs_t regs_init = '{state: st_idle, default: '0};

  regs_t       r, r_n;
  logic        accept;
  logic        ready_q;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^mem_in.mem_addr[1:0];

  // Next-state: new requests are only taken in idle or in the response cycle.
  always_comb begin
    r_n    = r;
    accept = 1'b0;
    case (r.state)
      st_idle: accept = mem_in.mem_valid;
      st_wait: begin
        if (r.cnt == 4'd0) r_n.state = st_resp;
        else               r_n.cnt   = r.cnt - 4'd1;
      end
      st_resp: begin
        r_n.state = st_idle;
        accept    = mem_in.mem_valid;
      end
      default: r_n.state = st_idle;
    endcase
    if (accept) begin
      r_n.idx      = mem_in.mem_addr[ram_depth+1:2];
      r_n.wdata    = mem_in.mem_wdata;
      r_n.wstrb    = mem_in.mem_wstrb;
      r_n.write    = (|mem_in.mem_wstrb) & ~mem_in.mem_instr;
      r_n.in_range = (mem_in.mem_addr[31:tag_lsb] == base_addr[31:tag_lsb]);
      if (wait_cycles == 0) begin
        r_n.state = st_resp;
      end else begin
        r_n.state = st_wait;
        r_n.cnt   = 4'(wait_cycles - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r       <= regs_init;
      ready_q <= 1'b0;
    end else begin
      r       <= r_n;
      ready_q <= (r_n.state == st_resp);
    end
  end

  // Writes commit at the end of the response cycle; reads launch on the edge entering it.
  assign ram_we = (r.state == st_resp) & r.write & r.in_range;
  assign ram_re = (r_n.state == st_resp) & ~r_n.write & r_n.in_range;

  imem_ram #(.ram_depth(ram_depth)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (r.idx),
    .wdata (r.wdata),
    .wstrb (r.wstrb),
    .re    (ram_re),
    .raddr (r_n.idx),
    .rdata (ram_rdata)
  );

  assign mem_out = '{mem_ready: ready_q, mem_rdata: ram_rdata};

  a_no_valid_in_wait: assert property (@(posedge clk) disable iff (!rst)
    !((r.state == st_wait) && mem_in.mem_valid))
    else $warning("imem_resp: mem_valid during wait state is ignored");

endmodule
